// File: rtl/exc_commit_ctrl_pkg.sv
// Shared exception/CSR definitions for the exception commit controller:
// exception codes, subcodes, FSM state encoding and the latched commit record.
package exc_commit_ctrl_pkg;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_PIF  = 6'h03;
    localparam logic [5:0] ECODE_PME  = 6'h04;
    localparam logic [5:0] ECODE_PPI  = 6'h07;
    localparam logic [5:0] ECODE_ADE  = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0b;
    localparam logic [5:0] ECODE_BRK  = 6'h0c;
    localparam logic [5:0] ECODE_INE  = 6'h0d;
    localparam logic [5:0] ECODE_IPE  = 6'h0e;
    localparam logic [5:0] ECODE_FPD  = 6'h0f;
    localparam logic [5:0] ECODE_TLBR = 6'h3f;

    localparam logic [8:0] ESUBCODE_NONE = 9'h000;
    localparam logic [8:0] ESUBCODE_ADEF = 9'h000;
    localparam logic [8:0] ESUBCODE_ADEM = 9'h001;

    // Default interrupt ecode; the top exposes it as an overridable parameter.
    localparam logic [5:0] ECODE_INT_DEFAULT = ECODE_INT;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COMMIT   = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    typedef struct packed {
        logic        is_ertn;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic [31:0] pc;
        logic [31:0] vaddr;
    } commit_info_t;

endpackage

// File: rtl/exc_commit_ctrl_if.sv
// Writeback / CSR / fetch-redirect signal bundle of the exception commit controller.
// slave is the controller side, master is the surrounding pipeline side.
interface exc_commit_ctrl_if;

    logic        wb_valid;
    logic [31:0] wb_pc;
    logic        wb_exc;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_vaddr;
    logic        wb_ertn;
    logic        wb_csr_we;
    logic        has_int;
    logic [31:0] ex_entry;
    logic [31:0] ex_epc;
    logic        wb_ready;
    logic        csr_we_gated;
    logic        csr_wb_ex;
    logic        csr_ertn_flush;
    logic [5:0]  csr_ecode;
    logic [8:0]  csr_esubcode;
    logic [31:0] csr_pc;
    logic [31:0] csr_vaddr;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    modport slave (
        input  wb_valid, wb_pc, wb_exc, wb_ecode, wb_esubcode, wb_vaddr,
               wb_ertn, wb_csr_we, has_int, ex_entry, ex_epc, redirect_ready,
        output wb_ready, csr_we_gated, csr_wb_ex, csr_ertn_flush, csr_ecode,
               csr_esubcode, csr_pc, csr_vaddr, flush, redirect_valid, redirect_pc
    );

    modport master (
        output wb_valid, wb_pc, wb_exc, wb_ecode, wb_esubcode, wb_vaddr,
               wb_ertn, wb_csr_we, has_int, ex_entry, ex_epc, redirect_ready,
        input  wb_ready, csr_we_gated, csr_wb_ex, csr_ertn_flush, csr_ecode,
               csr_esubcode, csr_pc, csr_vaddr, flush, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/exc_commit_ctrl.sv
// Exception / interrupt / ERTN commit sequencer between writeback, the CSR unit and fetch.
// IDLE accepts an event, COMMIT pulses the CSR unit, REDIRECT holds flush until fetch takes the target.
module exc_commit_ctrl
    import exc_commit_ctrl_pkg::*;
#(
    parameter int unsigned INT_HOLDOFF = 2,
    parameter logic [5:0]  ECODE_INT   = ECODE_INT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    exc_commit_ctrl_if.slave  bus
);

    localparam logic [3:0] HOLDOFF_LOAD = 4'(INT_HOLDOFF);

    state_t       state;
    state_t       state_next;
    commit_info_t info;
    commit_info_t info_next;
    logic [31:0]  target;
    logic [3:0]   holdoff;
    logic         take_int;
    logic         take_exc;
    logic         take_ertn;
    logic         accept;
    logic         ertn_done;

    // An interrupt outranks the instruction's own exception, which outranks ERTN.
    always_comb begin
        take_int  = bus.wb_valid && bus.has_int && (holdoff == 4'd0);
        take_exc  = bus.wb_valid && bus.wb_exc;
        take_ertn = bus.wb_valid && bus.wb_ertn;
        accept    = (state == ST_IDLE) && !reset && (take_int || take_exc || take_ertn);
        ertn_done = (state == ST_REDIRECT) && bus.redirect_ready && info.is_ertn;

        info_next.is_ertn  = !take_int && !take_exc;
        info_next.ecode    = take_int ? ECODE_INT : bus.wb_ecode;
        info_next.esubcode = take_int ? ESUBCODE_NONE : bus.wb_esubcode;
        info_next.pc       = bus.wb_pc;
        info_next.vaddr    = bus.wb_vaddr;
    end

    always_comb begin
        state_next         = state;
        bus.wb_ready       = 1'b0;
        bus.csr_we_gated   = 1'b0;
        bus.csr_wb_ex      = 1'b0;
        bus.csr_ertn_flush = 1'b0;
        bus.flush          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        unique case (state)
            ST_IDLE: begin
                bus.wb_ready     = 1'b1;
                bus.csr_we_gated = bus.wb_csr_we && bus.wb_valid && !accept;
                if (accept) begin
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                bus.csr_wb_ex      = !info.is_ertn;
                bus.csr_ertn_flush = info.is_ertn;
                bus.flush          = 1'b1;
                state_next         = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                bus.flush          = 1'b1;
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = target;
                if (bus.redirect_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.csr_ecode    = info.ecode;
    assign bus.csr_esubcode = info.esubcode;
    assign bus.csr_pc       = info.pc;
    assign bus.csr_vaddr    = info.vaddr;

    // Target is sampled in COMMIT, before the CSR unit applies this commit's update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            info    <= '0;
            target  <= 32'h0;
            holdoff <= 4'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                info <= info_next;
            end
            if (state == ST_COMMIT) begin
                target <= info.is_ertn ? bus.ex_epc : bus.ex_entry;
            end
            if (ertn_done) begin
                holdoff <= HOLDOFF_LOAD;
            end else if (holdoff != 4'd0) begin
                holdoff <= holdoff - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Self-checking bench for exc_commit_ctrl: vector table, directed corner sequences and
// randomized traffic checked against a cycle-age reference model.
module tb_exc_commit_ctrl;
    import exc_commit_ctrl_pkg::*;

    localparam int         HOLDOFF = 2;
    localparam logic [5:0] ECODE_INT_TB = 6'h00;
    localparam logic [31:0] VA = 32'h8000_1234;

    typedef struct packed {
        logic        reset;
        logic        wb_valid;
        logic [31:0] wb_pc;
        logic        wb_exc;
        logic [5:0]  wb_ecode;
        logic [8:0]  wb_esubcode;
        logic [31:0] wb_vaddr;
        logic        wb_ertn;
        logic        wb_csr_we;
        logic        has_int;
        logic [31:0] ex_entry;
        logic [31:0] ex_epc;
        logic        redirect_ready;
    } stim_t;

    typedef struct packed {
        logic        wb_ready;
        logic        csr_we_gated;
        logic        csr_wb_ex;
        logic        csr_ertn_flush;
        logic [5:0]  csr_ecode;
        logic [8:0]  csr_esubcode;
        logic [31:0] csr_pc;
        logic [31:0] csr_vaddr;
        logic        flush;
        logic        redirect_valid;
        logic [31:0] redirect_pc;
    } resp_t;

    typedef struct packed {
        stim_t s;
        resp_t r;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    exc_commit_ctrl_if bus ();

    exc_commit_ctrl #(
        .INT_HOLDOFF (HOLDOFF),
        .ECODE_INT   (ECODE_INT_TB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model: "age" counts cycles since an event was taken (1 = CSR pulse cycle).
    bit          m_busy;
    int          m_age;
    bit          m_ertn;
    logic [5:0]  m_ecode;
    logic [8:0]  m_esub;
    logic [31:0] m_pc;
    logic [31:0] m_vaddr;
    logic [31:0] m_target;
    int          m_hold;

    function automatic resp_t predict(input stim_t s);
        resp_t r;
        bit    evt;
        r = '0;
        r.csr_ecode    = m_ecode;
        r.csr_esubcode = m_esub;
        r.csr_pc       = m_pc;
        r.csr_vaddr    = m_vaddr;
        if (!m_busy) begin
            evt = s.wb_valid && !s.reset && ((s.has_int && m_hold == 0) || s.wb_exc || s.wb_ertn);
            r.wb_ready     = 1'b1;
            r.csr_we_gated = s.wb_valid && s.wb_csr_we && !evt;
        end else if (m_age == 1) begin
            r.csr_wb_ex      = !m_ertn;
            r.csr_ertn_flush = m_ertn;
            r.flush          = 1'b1;
        end else begin
            r.flush          = 1'b1;
            r.redirect_valid = 1'b1;
            r.redirect_pc    = m_target;
        end
        return r;
    endfunction

    task automatic modelUpdate(input stim_t s);
        int nh;
        bit irq;
        if (s.reset) begin
            m_busy = 0; m_age = 0; m_hold = 0; m_ertn = 0;
            m_ecode = '0; m_esub = '0; m_pc = '0; m_vaddr = '0; m_target = '0;
        end else begin
            nh = (m_hold > 0) ? m_hold - 1 : 0;
            if (!m_busy) begin
                irq = s.has_int && (m_hold == 0);
                if (s.wb_valid && (irq || s.wb_exc || s.wb_ertn)) begin
                    m_busy  = 1;
                    m_age   = 1;
                    m_ertn  = !irq && !s.wb_exc;
                    m_ecode = irq ? ECODE_INT_TB : s.wb_ecode;
                    m_esub  = irq ? 9'h000 : s.wb_esubcode;
                    m_pc    = s.wb_pc;
                    m_vaddr = s.wb_vaddr;
                end
            end else if (m_age == 1) begin
                m_target = m_ertn ? s.ex_epc : s.ex_entry;
                m_age    = 2;
            end else if (s.redirect_ready) begin
                m_busy = 0;
                if (m_ertn) nh = HOLDOFF;
            end
            m_hold = nh;
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        reset              = s.reset;
        bus.wb_valid       = s.wb_valid;
        bus.wb_pc          = s.wb_pc;
        bus.wb_exc         = s.wb_exc;
        bus.wb_ecode       = s.wb_ecode;
        bus.wb_esubcode    = s.wb_esubcode;
        bus.wb_vaddr       = s.wb_vaddr;
        bus.wb_ertn        = s.wb_ertn;
        bus.wb_csr_we      = s.wb_csr_we;
        bus.has_int        = s.has_int;
        bus.ex_entry       = s.ex_entry;
        bus.ex_epc         = s.ex_epc;
        bus.redirect_ready = s.redirect_ready;
    endtask

    function automatic resp_t readOutputs();
        resp_t r;
        r.wb_ready       = bus.wb_ready;
        r.csr_we_gated   = bus.csr_we_gated;
        r.csr_wb_ex      = bus.csr_wb_ex;
        r.csr_ertn_flush = bus.csr_ertn_flush;
        r.csr_ecode      = bus.csr_ecode;
        r.csr_esubcode   = bus.csr_esubcode;
        r.csr_pc         = bus.csr_pc;
        r.csr_vaddr      = bus.csr_vaddr;
        r.flush          = bus.flush;
        r.redirect_valid = bus.redirect_valid;
        r.redirect_pc    = bus.redirect_pc;
        return r;
    endfunction

    task automatic cmpField(input string tag, input string name,
                            input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s.%s: got %h, expected %h (t=%0t)", tag, name, act, req, $time);
        end
    endtask

    task automatic checkOutput(input resp_t got, input resp_t exp, input string tag);
        cmpField(tag, "wb_ready",       32'(got.wb_ready),       32'(exp.wb_ready));
        cmpField(tag, "csr_we_gated",   32'(got.csr_we_gated),   32'(exp.csr_we_gated));
        cmpField(tag, "csr_wb_ex",      32'(got.csr_wb_ex),      32'(exp.csr_wb_ex));
        cmpField(tag, "csr_ertn_flush", 32'(got.csr_ertn_flush), 32'(exp.csr_ertn_flush));
        cmpField(tag, "csr_ecode",      32'(got.csr_ecode),      32'(exp.csr_ecode));
        cmpField(tag, "csr_esubcode",   32'(got.csr_esubcode),   32'(exp.csr_esubcode));
        cmpField(tag, "csr_pc",         got.csr_pc,              exp.csr_pc);
        cmpField(tag, "csr_vaddr",      got.csr_vaddr,           exp.csr_vaddr);
        cmpField(tag, "flush",          32'(got.flush),          32'(exp.flush));
        cmpField(tag, "redirect_valid", 32'(got.redirect_valid), 32'(exp.redirect_valid));
        cmpField(tag, "redirect_pc",    got.redirect_pc,         exp.redirect_pc);
    endtask

    // One clock: drive after the edge, check at the falling edge, advance the model at the rising edge.
    task automatic stepCycle(input stim_t s, output resp_t got);
        applyStimulus(s);
        @(negedge clk);
        got = readOutputs();
        checkOutput(got, predict(s), "model");
        @(posedge clk);
        modelUpdate(s);
        #1;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.redirect_ready = 1'b1;
        s.ex_entry       = 32'h1c00_8000;
        s.ex_epc         = 32'h1c00_0204;
        return s;
    endfunction

    function automatic stim_t st(input logic rst, input logic v, input logic [31:0] pc,
                                 input logic exc, input logic [5:0] ec, input logic ertn,
                                 input logic we, input logic irq, input logic rdy);
        stim_t s;
        s = idle();
        s.reset = rst; s.wb_valid = v; s.wb_pc = pc; s.wb_exc = exc; s.wb_ecode = ec;
        s.wb_ertn = ertn; s.wb_csr_we = we; s.has_int = irq; s.redirect_ready = rdy;
        s.wb_vaddr = VA;
        return s;
    endfunction

    function automatic resp_t rs(input logic rdy, input logic we, input logic wbex, input logic ertnf,
                                 input logic [5:0] ec, input logic [31:0] pc, input logic [31:0] va,
                                 input logic fl, input logic rv, input logic [31:0] rpc);
        resp_t r;
        r = '0;
        r.wb_ready = rdy; r.csr_we_gated = we; r.csr_wb_ex = wbex; r.csr_ertn_flush = ertnf;
        r.csr_ecode = ec; r.csr_pc = pc; r.csr_vaddr = va; r.flush = fl;
        r.redirect_valid = rv; r.redirect_pc = rpc;
        return r;
    endfunction

    vec_t tbl [12];

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        stim_t s;
        resp_t got;
        int    rv_cnt;
        int    first;

        // Exception round trip and interrupt-on-next-valid, cycle by cycle from reset.
        tbl[0]  = '{s: st(1, 1, 32'h1c0000f0, 1, 6'h09, 0, 1, 0, 1), r: rs(1, 1, 0, 0, 6'h00, 32'h0, 32'h0, 0, 0, 32'h0)};
        tbl[1]  = '{s: st(0, 1, 32'h1c0000f0, 0, 6'h00, 0, 1, 0, 1), r: rs(1, 1, 0, 0, 6'h00, 32'h0, 32'h0, 0, 0, 32'h0)};
        tbl[2]  = '{s: st(0, 0, 32'h1c0000f4, 0, 6'h00, 0, 1, 0, 1), r: rs(1, 0, 0, 0, 6'h00, 32'h0, 32'h0, 0, 0, 32'h0)};
        tbl[3]  = '{s: st(0, 1, 32'h1c000100, 1, 6'h09, 0, 1, 0, 1), r: rs(1, 0, 0, 0, 6'h00, 32'h0, 32'h0, 0, 0, 32'h0)};
        tbl[4]  = '{s: st(0, 0, 32'h0,        0, 6'h00, 0, 0, 0, 1), r: rs(0, 0, 1, 0, 6'h09, 32'h1c000100, VA, 1, 0, 32'h0)};
        tbl[5]  = '{s: st(0, 0, 32'h0,        0, 6'h00, 0, 0, 0, 1), r: rs(0, 0, 0, 0, 6'h09, 32'h1c000100, VA, 1, 1, 32'h1c008000)};
        tbl[6]  = '{s: st(0, 1, 32'h1c000104, 0, 6'h00, 0, 1, 0, 1), r: rs(1, 1, 0, 0, 6'h09, 32'h1c000100, VA, 0, 0, 32'h0)};
        tbl[7]  = '{s: st(0, 0, 32'h0,        0, 6'h00, 0, 0, 1, 1), r: rs(1, 0, 0, 0, 6'h09, 32'h1c000100, VA, 0, 0, 32'h0)};
        tbl[8]  = '{s: st(0, 1, 32'h1c000108, 0, 6'h00, 0, 1, 1, 1), r: rs(1, 0, 0, 0, 6'h09, 32'h1c000100, VA, 0, 0, 32'h0)};
        tbl[9]  = '{s: st(0, 0, 32'h0,        0, 6'h00, 0, 0, 0, 1), r: rs(0, 0, 1, 0, 6'h00, 32'h1c000108, VA, 1, 0, 32'h0)};
        tbl[10] = '{s: st(0, 0, 32'h0,        0, 6'h00, 0, 0, 0, 1), r: rs(0, 0, 0, 0, 6'h00, 32'h1c000108, VA, 1, 1, 32'h1c008000)};
        tbl[11] = '{s: st(0, 0, 32'h0,        0, 6'h00, 0, 0, 0, 1), r: rs(1, 0, 0, 0, 6'h00, 32'h1c000108, VA, 0, 0, 32'h0)};

        s = idle();
        s.reset = 1'b1;
        applyStimulus(s);
        repeat (2) @(posedge clk);
        modelUpdate(s);
        #1;

        $display("[TB] table vectors");
        for (int i = 0; i < 12; i++) begin
            stepCycle(tbl[i].s, got);
            checkOutput(got, tbl[i].r, $sformatf("tbl%0d", i));
        end

        $display("[TB] ERTN with stalled fetch");
        s = idle(); s.wb_valid = 1; s.wb_ertn = 1; s.wb_pc = 32'h1c000200; s.wb_csr_we = 1; s.redirect_ready = 0;
        stepCycle(s, got);
        cmpField("ertn", "we_gated_at_accept", 32'(got.csr_we_gated), 32'd0);
        s = idle(); s.redirect_ready = 0;
        stepCycle(s, got);
        cmpField("ertn", "ertn_flush_pulse", 32'(got.csr_ertn_flush), 32'd1);
        cmpField("ertn", "no_wb_ex", 32'(got.csr_wb_ex), 32'd0);
        rv_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            s = idle(); s.redirect_ready = (i == 3);
            stepCycle(s, got);
            if (got.redirect_valid) rv_cnt++;
            cmpField("ertn", "redirect_pc_stable", got.redirect_pc, 32'h1c000204);
            cmpField("ertn", "wb_ready_low", 32'(got.wb_ready), 32'd0);
        end
        cmpField("ertn", "redirect_valid_cycles", 32'(rv_cnt), 32'd4);

        $display("[TB] interrupt holdoff after ERTN");
        first = -1;
        for (int i = 0; i < 6; i++) begin
            s = idle(); s.wb_valid = 1; s.has_int = 1; s.wb_csr_we = 1; s.wb_pc = 32'h1c000300 + 32'(4 * i);
            stepCycle(s, got);
            if (got.csr_we_gated == 1'b0) first = i;
            if (first >= 0) break;
        end
        cmpField("holdoff", "accept_cycle", 32'(first), 32'd2);
        s = idle();
        stepCycle(s, got);
        cmpField("holdoff", "irq_wb_ex", 32'(got.csr_wb_ex), 32'd1);
        cmpField("holdoff", "irq_ecode", 32'(got.csr_ecode), 32'(ECODE_INT_TB));
        cmpField("holdoff", "irq_pc", got.csr_pc, 32'h1c000308);
        stepCycle(s, got);

        $display("[TB] interrupt priority and reset mid-redirect");
        s = idle(); s.wb_valid = 1; s.has_int = 1; s.wb_exc = 1; s.wb_ecode = 6'h0b;
        s.wb_esubcode = 9'h005; s.wb_csr_we = 1; s.wb_pc = 32'h1c000380;
        stepCycle(s, got);
        cmpField("prio", "we_gated", 32'(got.csr_we_gated), 32'd0);
        s = idle(); s.redirect_ready = 0;
        stepCycle(s, got);
        cmpField("prio", "ecode", 32'(got.csr_ecode), 32'h00);
        cmpField("prio", "esubcode", 32'(got.csr_esubcode), 32'h0);
        cmpField("prio", "wb_ex", 32'(got.csr_wb_ex), 32'd1);
        stepCycle(s, got);
        cmpField("rst", "in_redirect", 32'(got.redirect_valid), 32'd1);
        s.reset = 1;
        stepCycle(s, got);
        s = idle(); s.redirect_ready = 0;
        stepCycle(s, got);
        cmpField("rst", "redirect_valid", 32'(got.redirect_valid), 32'd0);
        cmpField("rst", "flush", 32'(got.flush), 32'd0);
        cmpField("rst", "wb_ready", 32'(got.wb_ready), 32'd1);
        s = idle(); s.wb_valid = 1; s.wb_exc = 1; s.wb_ecode = 6'h09; s.wb_pc = 32'h1c000400;
        stepCycle(s, got);
        s = idle();
        stepCycle(s, got);
        cmpField("rst", "fresh_wb_ex", 32'(got.csr_wb_ex), 32'd1);
        cmpField("rst", "fresh_pc", got.csr_pc, 32'h1c000400);
        stepCycle(s, got);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 600; n++) begin
            s = '0;
            s.reset          = ($urandom_range(0, 99) < 2);
            s.wb_valid       = ($urandom_range(0, 99) < 70);
            s.wb_pc          = $urandom;
            s.wb_exc         = ($urandom_range(0, 99) < 15);
            s.wb_ecode       = 6'($urandom);
            s.wb_esubcode    = 9'($urandom);
            s.wb_vaddr       = $urandom;
            s.wb_ertn        = ($urandom_range(0, 99) < 15);
            s.wb_csr_we      = ($urandom_range(0, 99) < 50);
            s.has_int        = ($urandom_range(0, 99) < 15);
            s.ex_entry       = $urandom;
            s.ex_epc         = $urandom;
            s.redirect_ready = ($urandom_range(0, 99) < 60);
            stepCycle(s, got);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exc_commit_ctrl.md
Name: exc_commit_ctrl

Overview:
- Sequences exception, interrupt and ERTN commit between the writeback stage and the CSR unit.
- Arbitrates the three event sources and drives the CSR unit's one-cycle wb_ex / ertn_flush pulses with the exception fields.
- Holds the pipeline flushed and the writeback stage stalled until fetch accepts a redirect to the exception entry or return address.
- Gates CSR writes from the instruction that is being cancelled.

Parameters:
INT_HOLDOFF, 2, cycles after an ERTN redirect completes during which has_int is ignored (range 0..15).
ECODE_INT, 6'h00, ecode reported for an interrupt.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
wb_valid  in  1  writeback stage holds a valid instruction
wb_pc  in  32  PC of the writeback instruction
wb_exc  in  1  writeback instruction raised an exception
wb_ecode  in  6  exception code
wb_esubcode  in  9  exception subcode
wb_vaddr  in  32  faulting data address
wb_ertn  in  1  writeback instruction is ERTN
wb_csr_we  in  1  writeback instruction requests a CSR write
has_int  in  1  pending enabled interrupt, from CSR unit
ex_entry  in  32  exception entry address, from CSR unit
ex_epc  in  32  return address (ERA), from CSR unit
wb_ready  out  1  writeback stage may retire
csr_we_gated  out  1  CSR write enable forwarded to CSR unit
csr_wb_ex  out  1  exception commit pulse
csr_ertn_flush  out  1  ERTN commit pulse
csr_ecode  out  6  latched ecode
csr_esubcode  out  9  latched esubcode
csr_pc  out  32  latched PC
csr_vaddr  out  32  latched vaddr
flush  out  1  cancel all younger pipeline stages
redirect_valid  out  1  redirect request to fetch
redirect_pc  out  32  redirect target
redirect_ready  in  1  fetch accepts the redirect

Behaviour:
- Reset (also mid-operation): state returns to IDLE and the holdoff counter clears.
  - All outputs are 0, except wb_ready=1 and csr_we_gated = wb_csr_we & wb_valid.
- States: IDLE, COMMIT, REDIRECT.
- IDLE accepts an event only when wb_valid=1. Priority:
  - interrupt: has_int=1 and holdoff counter 0; ecode ECODE_INT, esubcode 0;
  - then wb_exc;
  - then wb_ertn.
  - Interrupt ecode/esubcode replace the instruction's own exception.
- On accept (cycle T), latch kind, pc=wb_pc, vaddr=wb_vaddr, ecode and esubcode, then go to COMMIT.
  - csr_we_gated=0 in cycle T; no CSR write from a cancelled or ERTN instruction.
  - wb_ready stays 1 in cycle T; the faulting instruction is consumed.
- IDLE with no event: csr_we_gated = wb_csr_we & wb_valid.
- has_int with wb_valid=0: no action; the interrupt is taken on the next valid instruction.
- COMMIT (T+1), exactly one cycle:
  - csr_wb_ex=1 for an exception or interrupt, csr_ertn_flush=1 for ERTN; never both.
  - csr_* field outputs valid and held until the next accept.
  - flush=1, wb_ready=0.
  - Latch target: ex_entry for an exception or interrupt, ex_epc for ERTN. Both are sampled in this cycle, which is before the CSR update takes effect.
  - Next state REDIRECT.
- REDIRECT (T+2 onward):
  - redirect_valid=1, redirect_pc=target, flush=1, wb_ready=0.
  - redirect_pc stays stable while redirect_valid=1 and redirect_ready=0.
  - When redirect_ready=1, go to IDLE the next cycle and drop redirect_valid and flush.
  - A redirect_ready already high in the first REDIRECT cycle completes the redirect in 1 cycle.
  - Minimum event-to-IDLE latency is 3 cycles.
- Holdoff counter:
  - Loaded with INT_HOLDOFF when an ERTN redirect completes.
  - Decrements each cycle while nonzero; saturates at 0.
  - Wb_exc and wb_ertn are still accepted during holdoff.
- All inputs are ignored outside IDLE, apart from redirect_ready in REDIRECT and the ex_entry/ex_epc sample in COMMIT.
- The target is a full 32 bits; no alignment is applied.

Decomposition:
- Shared package: ECODE_* and ESUBCODE_* constants (already in the exception/CSR header), the ECODE_INT default, and the state encoding localparams.
- No sub-module is needed. The holdoff counter is a 4-bit register inside this block.

Test Plan:
- Exception:
  - Stimulus: wb_valid=1, wb_exc=1, ecode=6'h09, wb_pc=0x1c000100, ex_entry=0x1c008000, redirect_ready tied 1.
  - Response: csr_wb_ex pulse at T+1 with csr_pc=0x1c000100 and csr_ecode=0x09; redirect_pc=0x1c008000 at T+2; IDLE at T+3; flush high T+1..T+2.
- ERTN with stalled fetch:
  - Stimulus: wb_ertn=1, ex_epc=0x1c000204, redirect_ready low for 3 cycles.
  - Response: csr_ertn_flush pulse only; redirect_valid held 4 cycles with a stable pc; wb_ready=0 throughout.
- Interrupt priority:
  - Stimulus: has_int=1 together with wb_exc=1 (ecode 0x0b), wb_csr_we=1.
  - Response: csr_ecode=0x00, csr_esubcode=0; csr_we_gated=0.
- Holdoff:
  - Stimulus: ERTN completes, then has_int=1 with continuous wb_valid.
  - Response: interrupt ignored for 2 cycles, accepted on the 3rd.
- Reset mid-REDIRECT:
  - Stimulus: assert reset while redirect_valid=1.
  - Response: next cycle redirect_valid=0, flush=0, wb_ready=1; a fresh event is accepted normally.
- Normal CSR write:
  - Stimulus: wb_valid=1, wb_csr_we=1, no event.
  - Response: csr_we_gated=1 in the same cycle; no flush.
